mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 1, meaning extra SRAM access cycles beyond the first (legal 0..7).
REQ-002 SHALL provide Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide Req_RD  input  1  read request from control unit, level, held until Ready.
REQ-005 SHALL provide Req_WR  input  1  write request from control unit, level, held until Ready.
REQ-006 SHALL provide ADDR  input  16  word address (MAR value).
REQ-007 SHALL provide Data_from_CPU  input  16  write data (MDR value).
REQ-008 SHALL provide Data_to_CPU  output  16  registered read data for MDR load.
REQ-009 SHALL provide Ready  output  1  access complete; high while request still held.
REQ-010 SHALL provide Switches  input  16  board switch value, memory-mapped read at 16'hFFFF.
REQ-011 SHALL provide HEX_Data  output  16  hex-display register, memory-mapped write at 16'hFFFF.
REQ-012 SHALL provide SRAM_ADDR  output  20  {4'h0, latched ADDR}.
REQ-013 SHALL provide SRAM_DQ_in  input  16  SRAM read data; SRAM_DQ_out  output  16  SRAM write data; SRAM_DQ_oe  output  1  1 = drive bus.
REQ-014 SHALL provide Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  output  1 each  active-low SRAM strobes.

Function
REQ-015 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-016 IDLE: on Req_RD=1, latch ADDR; ADDR=16'hFFFF -> capture Switches into Data_to_CPU, go DONE; else go READ.
REQ-017 IDLE: on Req_WR=1 (Req_RD=0), latch ADDR and Data_from_CPU; ADDR=16'hFFFF -> load HEX_Data, go DONE; else go WRITE.
REQ-018 Req_RD and Req_WR both high in IDLE SHALL be treated as read only; write ignored.
REQ-019 READ: Mem_OE=0 for exactly WAIT_CYCLES+1 cycles; on the edge ending the last cycle capture SRAM_DQ_in into Data_to_CPU and go DONE.
REQ-020 WRITE: Mem_WE=0, SRAM_DQ_oe=1, SRAM_DQ_out=latched data for exactly WAIT_CYCLES+1 cycles, then go DONE; Mem_OE=1 throughout.
REQ-021 Mem_OE and Mem_WE SHALL never be low in the same cycle; both high in IDLE and DONE.
REQ-022 DONE: Ready=1; remain in DONE while Req_RD or Req_WR high; go IDLE on first cycle both are low (Ready low from that cycle onward).
REQ-023 SRAM latency: request seen at edge E0 -> Ready high after edge E(WAIT_CYCLES+1); MMIO latency: Ready high after E0.
REQ-024 Wait counter SHALL be 3 bits, cleared on entry to READ/WRITE, no wrap beyond WAIT_CYCLES.
REQ-025 ADDR/Data_from_CPU changes after latching SHALL not affect the ongoing access.
REQ-026 Data_to_CPU SHALL hold its value until the next read completes; HEX_Data until the next MMIO write.
REQ-027 Mem_CE, Mem_UB, Mem_LB SHALL be constant 0.

Reset
REQ-028 Reset=1 at an edge SHALL force IDLE, Ready=0, Data_to_CPU=0, HEX_Data=0, counter=0, Mem_OE=1, Mem_WE=1, SRAM_DQ_oe=0.
REQ-029 Reset during READ/WRITE SHALL abort next edge; no retry, no Ready, partial SRAM write permitted.
REQ-030 Requests high while Reset=1 SHALL be ignored; a request still held after release starts a new access.

Verification
REQ-031 WAIT_CYCLES=1, SRAM word 16'h1234 at 0x0040, Req_RD -> Mem_OE low 2 cycles, Ready in 3rd cycle, Data_to_CPU=16'h1234.
REQ-032 Req_WR ADDR=0x0041 data 16'hBEEF -> Mem_WE low 2 cycles, SRAM_DQ_oe=1, readback 16'hBEEF; Mem_OE never low with Mem_WE.
REQ-033 Switches=16'h00A5, Req_RD ADDR=16'hFFFF -> Ready after 1 edge, Data_to_CPU=16'h00A5, Mem_OE stays 1.
REQ-034 Req_WR ADDR=16'hFFFF data 16'h0C0D -> HEX_Data=16'h0C0D, no Mem_WE pulse; Req_RD+Req_WR together -> read only.
REQ-035 Hold request 5 cycles after Ready -> Ready stays 1, single access; drop -> IDLE, Ready 0 next cycle.
REQ-036 Reset asserted in WRITE's first cycle -> next cycle Mem_WE=1, SRAM_DQ_oe=0, Ready=0, HEX_Data=0.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: bundles the CPU-side request/data signals, the memory-mapped
// switch/hex I/O and the SRAM bus of mem_access_ctrl.
//   master : CPU / board side (drives requests, switches, SRAM read data)
//   slave  : the controller (drives read data, Ready, hex register, SRAM strobes)
interface mem_access_ctrl_if;
  logic        Req_RD;
  logic        Req_WR;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;
  logic        Ready;
  logic [15:0] Switches;
  logic [15:0] HEX_Data;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_in;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic        Mem_CE;
  logic        Mem_UB;
  logic        Mem_LB;
  logic        Mem_OE;
  logic        Mem_WE;

  modport master (
    output Req_RD, Req_WR, ADDR, Data_from_CPU, Switches, SRAM_DQ_in,
    input  Data_to_CPU, Ready, HEX_Data, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
           Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport slave (
    input  Req_RD, Req_WR, ADDR, Data_from_CPU, Switches, SRAM_DQ_in,
    output Data_to_CPU, Ready, HEX_Data, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
           Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-port SRAM access controller for a 16-bit CPU with one
// memory-mapped I/O word at 16'hFFFF (read = board switches, write = hex display).
// Ports:
//   Clk     - sole clock, rising edge
//   Reset   - synchronous, active-high
//   io_bus  - mem_access_ctrl_if.slave: CPU requests/data, Ready, Switches, HEX_Data,
//             SRAM address/data/output-enable and active-low SRAM strobes
// Parameter WAIT_CYCLES (0..7): extra SRAM access cycles beyond the first.
// All outputs are registered; the FSM updates state and strobes together.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic              Clk,
  input logic              Reset,
  mem_access_ctrl_if.slave io_bus
);

  localparam logic [15:0] MmioAddr = 16'hFFFF;
  localparam logic [2:0]  LastCnt  = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      r_state;
  logic [2:0]  r_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic [15:0] r_hex;
  logic        r_ready;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_dq_oe;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StIdle;
      r_cnt   <= 3'd0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
      r_hex   <= 16'h0000;
      r_ready <= 1'b0;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_dq_oe <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          // A simultaneous read and write request is served as a read only.
          if (io_bus.Req_RD) begin
            r_addr <= io_bus.ADDR;
            if (io_bus.ADDR == MmioAddr) begin
              r_rdata <= io_bus.Switches;
              r_ready <= 1'b1;
              r_state <= StDone;
            end else begin
              r_cnt   <= 3'd0;
              r_oe_n  <= 1'b0;
              r_state <= StRead;
            end
          end else if (io_bus.Req_WR) begin
            r_addr  <= io_bus.ADDR;
            r_wdata <= io_bus.Data_from_CPU;
            if (io_bus.ADDR == MmioAddr) begin
              r_hex   <= io_bus.Data_from_CPU;
              r_ready <= 1'b1;
              r_state <= StDone;
            end else begin
              r_cnt   <= 3'd0;
              r_we_n  <= 1'b0;
              r_dq_oe <= 1'b1;
              r_state <= StWrite;
            end
          end
        end
        StRead: begin
          // Strobe already spans WAIT_CYCLES+1 cycles when the count reaches LastCnt.
          if (r_cnt == LastCnt) begin
            r_rdata <= io_bus.SRAM_DQ_in;
            r_oe_n  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        StWrite: begin
          if (r_cnt == LastCnt) begin
            r_we_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            r_ready <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        StDone: begin
          if (!io_bus.Req_RD && !io_bus.Req_WR) begin
            r_ready <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_oe_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_dq_oe <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_bus.Data_to_CPU = r_rdata;
  assign io_bus.Ready       = r_ready;
  assign io_bus.HEX_Data    = r_hex;
  assign io_bus.SRAM_ADDR   = {4'h0, r_addr};
  assign io_bus.SRAM_DQ_out = r_wdata;
  assign io_bus.SRAM_DQ_oe  = r_dq_oe;
  assign io_bus.Mem_CE      = 1'b0;
  assign io_bus.Mem_UB      = 1'b0;
  assign io_bus.Mem_LB      = 1'b0;
  assign io_bus.Mem_OE      = r_oe_n;
  assign io_bus.Mem_WE      = r_we_n;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed scenarios followed by random accesses,
// checked against a word-level memory/register model kept in the bench.
module tb_mem_access_ctrl;
  localparam int unsigned W = 1;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .io_bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // Preloaded SRAM contents for words never written during the run.
  function automatic logic [15:0] preload(input logic [15:0] a);
    return (a == 16'h0040) ? 16'h1234 : {a[7:0], ~a[7:0]};
  endfunction

  // SRAM device model: write on a clock edge while WE is low and the bus is driven.
  logic [15:0] sram [0:65535];
  bit          sram_wr [0:65535];
  logic [15:0] sa;
  assign sa = bus.SRAM_ADDR[15:0];
  always @(posedge Clk) begin
    if (!bus.Mem_WE && bus.SRAM_DQ_oe) begin
      sram[sa]    <= bus.SRAM_DQ_out;
      sram_wr[sa] <= 1'b1;
    end
  end
  assign bus.SRAM_DQ_in = !bus.Mem_OE ? (sram_wr[sa] ? sram[sa] : preload(sa)) : 16'hDEAD;

  // Reference model: intended memory contents and output registers.
  logic [15:0] ref_mem [int];
  logic [15:0] exp_dout;
  logic [15:0] exp_hex;

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : preload(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU access: request, wait for Ready, hold, drop.
  task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, input logic [15:0] sw, input int hold);
    int edges, oe_low, we_low, both;
    bit mmio, is_rd, is_wr;
    is_rd = rd;
    is_wr = wr && !rd;
    mmio  = (addr == 16'hFFFF);
    @(negedge Clk);
    Reset             = 1'b0;
    bus.Req_RD        = rd;
    bus.Req_WR        = wr;
    bus.ADDR          = addr;
    bus.Data_from_CPU = data;
    bus.Switches      = sw;
    edges = 0; oe_low = 0; we_low = 0; both = 0;
    do begin
      @(posedge Clk); #1;
      edges++;
      if (edges == 1) begin
        // Inputs after the latching edge must not influence the access.
        bus.ADDR          = 16'($urandom_range(0, 16'hFFFE));
        bus.Data_from_CPU = 16'($urandom);
        bus.Switches      = 16'($urandom);
      end
      if (!bus.Mem_OE) begin
        oe_low++;
        chk("rd_sram_addr", 32'(bus.SRAM_ADDR), 32'({4'h0, addr}));
      end
      if (!bus.Mem_WE) begin
        we_low++;
        chk("wr_sram_addr", 32'(bus.SRAM_ADDR), 32'({4'h0, addr}));
        chk("wr_dq_oe", 32'(bus.SRAM_DQ_oe), 32'd1);
        chk("wr_dq_out", 32'(bus.SRAM_DQ_out), 32'(data));
      end
      if (!bus.Mem_OE && !bus.Mem_WE) both++;
    end while (!bus.Ready && edges < 20);
    chk("ready_seen", 32'(bus.Ready), 32'd1);
    chk("latency_edges", 32'(edges), mmio ? 32'd1 : 32'(W + 2));
    chk("oe_low_cycles", 32'(oe_low), (is_rd && !mmio) ? 32'(W + 1) : 32'd0);
    chk("we_low_cycles", 32'(we_low), (is_wr && !mmio) ? 32'(W + 1) : 32'd0);
    chk("oe_we_overlap", 32'(both), 32'd0);
    if (is_rd) exp_dout = mmio ? sw : ref_read(addr);
    else if (is_wr) begin
      if (mmio) exp_hex = data;
      else ref_mem[int'(addr)] = data;
    end
    chk("data_to_cpu", 32'(bus.Data_to_CPU), 32'(exp_dout));
    chk("hex_data", 32'(bus.HEX_Data), 32'(exp_hex));
    chk("done_strobes", 32'({bus.Mem_OE, bus.Mem_WE, bus.SRAM_DQ_oe}), 32'b110);
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      chk("ready_hold", 32'(bus.Ready), 32'd1);
      chk("hold_strobes", 32'({bus.Mem_OE, bus.Mem_WE}), 32'b11);
    end
    @(negedge Clk);
    bus.Req_RD = 1'b0;
    bus.Req_WR = 1'b0;
    @(posedge Clk); #1;
    chk("ready_drop", 32'(bus.Ready), 32'd0);
  endtask

  initial begin
    bus.Req_RD        = 1'b0;
    bus.Req_WR        = 1'b0;
    bus.ADDR          = 16'h0000;
    bus.Data_from_CPU = 16'h0000;
    bus.Switches      = 16'h0000;
    exp_dout          = 16'h0000;
    exp_hex           = 16'h0000;

    // Reset state.
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_ready", 32'(bus.Ready), 32'd0);
    chk("rst_dout", 32'(bus.Data_to_CPU), 32'd0);
    chk("rst_hex", 32'(bus.HEX_Data), 32'd0);
    chk("rst_strobes", 32'({bus.Mem_OE, bus.Mem_WE, bus.SRAM_DQ_oe}), 32'b110);
    chk("const_ce_ub_lb", 32'({bus.Mem_CE, bus.Mem_UB, bus.Mem_LB}), 32'd0);

    // SRAM read, SRAM write + readback, MMIO read/write, read-wins, long hold.
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 0);
    access(1'b0, 1'b1, 16'h0041, 16'hBEEF, 16'h0000, 0);
    access(1'b1, 1'b0, 16'h0041, 16'h0000, 16'h0000, 0);
    access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 0);
    access(1'b0, 1'b1, 16'hFFFF, 16'h0C0D, 16'h0000, 0);
    access(1'b1, 1'b1, 16'h0041, 16'h1111, 16'h0000, 0);
    access(1'b1, 1'b1, 16'hFFFF, 16'h2222, 16'h5A5A, 0);
    access(1'b1, 1'b0, 16'h0041, 16'h0000, 16'h0000, 5);

    // Reset in the first WRITE cycle aborts the access; requests during reset ignored.
    @(negedge Clk);
    bus.Req_WR        = 1'b1;
    bus.ADDR          = 16'h0200;
    bus.Data_from_CPU = 16'hA5A5;
    @(posedge Clk); #1;
    chk("abort_we_active", 32'(bus.Mem_WE), 32'd0);
    Reset      = 1'b1;
    bus.Req_RD = 1'b1;
    @(posedge Clk); #1;
    exp_dout = 16'h0000;
    exp_hex  = 16'h0000;
    chk("abort_strobes", 32'({bus.Mem_OE, bus.Mem_WE, bus.SRAM_DQ_oe}), 32'b110);
    chk("abort_ready", 32'(bus.Ready), 32'd0);
    chk("abort_hex", 32'(bus.HEX_Data), 32'd0);
    chk("abort_dout", 32'(bus.Data_to_CPU), 32'd0);
    @(posedge Clk); #1;
    chk("rst_req_ignored", 32'({bus.Ready, bus.Mem_OE, bus.Mem_WE}), 32'b011);
    // Request still held at release starts a fresh (read-only) access.
    access(1'b1, 1'b1, 16'h0040, 16'hA5A5, 16'h0000, 1);

    // Random accesses.
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [15:0] a;
      kind = int'($urandom_range(0, 2));
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 127));
      access(kind != 1, kind != 0, a, 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
